// File: rtl/constant_op_sequencer_if.sv
// Handshake and stage-facing signal bundle for constant_op_sequencer.
// The sequencer sits on the slave side; a driver or testbench uses the master side.
interface constant_op_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] start_value;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_select;
  logic             cmd_operation;
  logic             cmd_last;

  logic [WIDTH-1:0] stage_input;
  logic [1:0]       stage_constant_select;
  logic             stage_operation;
  logic [WIDTH-1:0] stage_result;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_value;
  logic             res_overflow;
  logic [3:0]       res_count;

  logic             busy;

  modport slave (
    input  start_valid, start_value,
    input  cmd_valid, cmd_select, cmd_operation, cmd_last,
    input  stage_result,
    input  res_ready,
    output start_ready, cmd_ready,
    output stage_input, stage_constant_select, stage_operation,
    output res_valid, res_value, res_overflow, res_count,
    output busy
  );

  modport master (
    output start_valid, start_value,
    output cmd_valid, cmd_select, cmd_operation, cmd_last,
    output stage_result,
    output res_ready,
    input  start_ready, cmd_ready,
    input  stage_input, stage_constant_select, stage_operation,
    input  res_valid, res_value, res_overflow, res_count,
    input  busy
  );
endinterface

// File: rtl/constant_op_sequencer.sv
// Control stage for the add/subtract-by-constant datapath: queues commands,
// steps a running accumulator through the external stage and returns the result.
module constant_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    reset,
  constant_op_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0] select;
    logic       operation;
    logic       last;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  cmd_t       fifo_mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  cmd_t       head;
  cmd_t       incoming;

  logic [WIDTH-1:0] acc;
  logic             overflow;
  logic [3:0]       count;
  logic             start_ready;
  logic             res_valid;
  logic             busy;
  logic             ovf;

  // The extra pointer bit separates a full FIFO from an empty one when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state == RUN) && !empty;
  assign head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  assign incoming.select    = bus.cmd_select;
  assign incoming.operation = bus.cmd_operation;
  assign incoming.last      = bus.cmd_last;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= incoming;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Signed overflow: operands share a sign (constant sign equals operation) and the result flips it.
  assign ovf = (acc[WIDTH-1] == head.operation) &&
               (bus.stage_result[WIDTH-1] != acc[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      overflow    <= 1'b0;
      count       <= '0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            acc         <= bus.start_value;
            overflow    <= 1'b0;
            count       <= '0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (pop) begin
            acc      <= bus.stage_result;
            overflow <= overflow | ovf;
            if (count != 4'hF) begin
              count <= count + 4'd1;
            end
            if (head.last) begin
              res_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Stage controls are only non-zero while a command is actually being consumed.
  assign bus.stage_input           = acc;
  assign bus.stage_constant_select = pop ? head.select : 2'd0;
  assign bus.stage_operation       = pop ? head.operation : 1'b0;

  assign bus.start_ready  = start_ready;
  assign bus.cmd_ready    = !full;
  assign bus.res_valid    = res_valid;
  assign bus.res_value    = acc;
  assign bus.res_overflow = overflow;
  assign bus.res_count    = count;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_constant_op_sequencer.sv
// Self-checking bench for constant_op_sequencer: directed scenarios plus random runs
// compared against a signed-integer reference model of the command sequence.
module tb_constant_op_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0] sel;
    logic       op;
    logic       last;
  } cmd_s;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   last_push_cyc = 0;
  cmd_s model_q[$];

  logic [7:0] obs_value;
  logic       obs_ovf;
  logic [3:0] obs_count;

  always #5 clk = ~clk;

  constant_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  constant_op_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural add/subtract-by-constant stage: constant is 2*select+1.
  assign bus.stage_result = bus.stage_operation ?
      8'(int'(bus.stage_input) - (2 * int'(bus.stage_constant_select) + 1)) :
      8'(int'(bus.stage_input) + (2 * int'(bus.stage_constant_select) + 1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; drops any valid that the DUT accepted at the edge.
  task automatic tick();
    bit took_cmd;
    bit took_start;
    took_cmd   = bus.cmd_valid && bus.cmd_ready;
    took_start = bus.start_valid && bus.start_ready;
    @(negedge clk);
    cyc++;
    if (took_cmd) begin
      bus.cmd_valid = 1'b0;
      last_push_cyc = cyc;
    end
    if (took_start) bus.start_valid = 1'b0;
  endtask

  task automatic predict(input logic [7:0] sv, output logic [7:0] v, output logic o,
                         output logic [3:0] c);
    int   a;
    int   n;
    int   k;
    cmd_s x;
    a = int'($signed(sv));
    o = 1'b0;
    n = 0;
    while (model_q.size() > 0) begin
      x = model_q.pop_front();
      k = 2 * int'(x.sel) + 1;
      a = x.op ? a - k : a + k;
      if (a > 127 || a < -128) o = 1'b1;
      if (a > 127) a -= 256;
      else if (a < -128) a += 256;
      n++;
      if (x.last) break;
    end
    v = 8'(a);
    c = (n > 15) ? 4'd15 : 4'(n);
  endtask

  task automatic push_cmd(input logic [1:0] sel, input logic op, input logic last);
    bus.cmd_select    = sel;
    bus.cmd_operation = op;
    bus.cmd_last      = last;
    bus.cmd_valid     = 1'b1;
    model_q.push_back('{sel, op, last});
    for (int i = 0; i < 40 && bus.cmd_valid; i++) tick();
    check("push_accept", 32'(bus.cmd_valid), 32'd0);
  endtask

  task automatic run_and_check(input logic [7:0] sv, input int exp_lat, input int hold);
    logic [7:0] ev;
    logic       eo;
    logic [3:0] ec;
    int         lat;
    predict(sv, ev, eo, ec);
    check("start_ready_idle", 32'(bus.start_ready), 32'd1);
    bus.start_value = sv;
    bus.start_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.res_valid && lat < 60);
    check("res_valid_seen", 32'(bus.res_valid), 32'd1);
    check("res_latency", 32'(lat), 32'(exp_lat));
    check("res_value", 32'(bus.res_value), 32'(ev));
    check("res_overflow", 32'(bus.res_overflow), 32'(eo));
    check("res_count", 32'(bus.res_count), 32'(ec));
    obs_value = bus.res_value;
    obs_ovf   = bus.res_overflow;
    obs_count = bus.res_count;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_value", 32'(bus.res_value), 32'(ev));
      check("hold_start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("post_res_valid", 32'(bus.res_valid), 32'd0);
    check("post_busy", 32'(bus.busy), 32'd0);
    check("post_start_ready", 32'(bus.start_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_cyc;
    int n;
    reset             = 1'b1;
    bus.start_valid   = 1'b0;
    bus.start_value   = '0;
    bus.cmd_valid     = 1'b0;
    bus.cmd_select    = '0;
    bus.cmd_operation = 1'b0;
    bus.cmd_last      = 1'b0;
    bus.res_ready     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_value", 32'(bus.res_value), 32'd0);
    check("rst_res_count", 32'(bus.res_count), 32'd0);
    check("rst_stage_sel", 32'(bus.stage_constant_select), 32'd0);

    // Two-command run, result in cycle 3.
    push_cmd(2'd1, 1'b0, 1'b0);
    push_cmd(2'd2, 1'b1, 1'b1);
    run_and_check(8'd10, 3, 2);
    check("t1_value", 32'(obs_value), 32'd8);
    check("t1_ovf", 32'(obs_ovf), 32'd0);
    check("t1_count", 32'(obs_count), 32'd2);

    push_cmd(2'd0, 1'b0, 1'b0);
    push_cmd(2'd0, 1'b0, 1'b1);
    run_and_check(8'h7E, 3, 0);
    check("t2_value", 32'(obs_value), 32'h80);
    check("t2_ovf", 32'(obs_ovf), 32'd1);

    push_cmd(2'd3, 1'b1, 1'b1);
    run_and_check(8'h00, 2, 0);
    check("t3a_value", 32'(obs_value), 32'hF9);
    check("t3a_ovf", 32'(obs_ovf), 32'd0);
    push_cmd(2'd0, 1'b1, 1'b1);
    run_and_check(8'h80, 2, 1);
    check("t3b_value", 32'(obs_value), 32'h7F);
    check("t3b_ovf", 32'(obs_ovf), 32'd1);

    // Fill the FIFO, leave a fifth command pending until the run frees a slot.
    for (int i = 0; i < 4; i++) push_cmd(2'(i), 1'(i % 2), 1'b0);
    check("t4_full", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_select    = 2'd3;
    bus.cmd_operation = 1'b0;
    bus.cmd_last      = 1'b1;
    bus.cmd_valid     = 1'b1;
    model_q.push_back('{2'd3, 1'b0, 1'b1});
    tick();
    tick();
    check("t4_pending", 32'(bus.cmd_valid), 32'd1);
    start_cyc = cyc;
    run_and_check(8'd50, 6, 0);
    check("t4_accept_cycle", 32'(last_push_cyc - start_cyc), 32'd3);
    check("t4_count", 32'(obs_count), 32'd5);

    // Start with an empty FIFO and stall before the only command arrives.
    bus.start_value = 8'd1;
    bus.start_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t5_stall_busy", 32'(bus.busy), 32'd1);
      check("t5_stall_acc", 32'(bus.stage_input), 32'd1);
      check("t5_stall_sel", 32'(bus.stage_constant_select), 32'd0);
      check("t5_stall_op", 32'(bus.stage_operation), 32'd0);
      tick();
    end
    bus.cmd_select    = 2'd1;
    bus.cmd_operation = 1'b0;
    bus.cmd_last      = 1'b1;
    bus.cmd_valid     = 1'b1;
    tick();
    check("t5_pop_sel", 32'(bus.stage_constant_select), 32'd1);
    check("t5_pop_valid", 32'(bus.res_valid), 32'd0);
    tick();
    check("t5_res_valid", 32'(bus.res_valid), 32'd1);
    check("t5_value", 32'(bus.res_value), 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_value", 32'(bus.res_value), 32'd4);
      check("t5_hold_start_ready", 32'(bus.start_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("t5_idle", 32'(bus.busy), 32'd0);

    // Reset mid-run with two commands still queued.
    for (int i = 0; i < 4; i++) push_cmd(2'd2, 1'b0, 1'(i == 3));
    bus.start_value = 8'h20;
    bus.start_valid = 1'b1;
    tick();
    tick();
    tick();
    check("t6_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_q.delete();
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_res_valid", 32'(bus.res_valid), 32'd0);
    check("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("t6_res_value", 32'(bus.res_value), 32'd0);
    push_cmd(2'd0, 1'b0, 1'b1);
    run_and_check(8'd0, 2, 0);
    check("t6_value", 32'(obs_value), 32'd1);

    // Random runs against the reference model.
    for (int r = 0; r < 10; r++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        push_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'(i == n - 1));
      end
      run_and_check(8'($urandom), n + 1, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
